// File: rtl/rr_shared_reg_arb_pkg.sv
// Shared types and width helpers for the round-robin shared-register arbiter.
package arb_pkg;

    // Arbiter sequencing states: IDLE (no owner) and OWN (register written by owner).
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Default configuration of the arbiter.
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    // Index and burst-count widths for the default configuration.
    localparam int DEF_IDX_W = $clog2(DEF_NUM_REQ);
    localparam int DEF_CNT_W = $clog2(DEF_MAX_BURST) + 1;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of the burst counter; one spare bit so MAX_BURST=1 still gets a flop.
    function automatic int cnt_width(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rr_shared_reg_arb_en_reg.sv
// Enabled register built from individual clear/preset flops.

// Single D flop with enable, asynchronous active-low clear and preset.
module d_en_ff (
    input  logic clk,
    input  logic CLRN,
    input  logic PRN,
    input  logic en,
    input  logic d,
    output logic q
);

    // Clear dominates preset; otherwise load d when enabled.
    always_ff @(posedge clk or negedge CLRN or negedge PRN) begin
        if (!CLRN) begin
            q <= 1'b0;
        end else if (!PRN) begin
            q <= 1'b1;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// WIDTH-bit enabled register; preset is never used so it is tied inactive.
module en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             CLRN,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_en_ff u_ff (
            .clk  (clk),
            .CLRN (CLRN),
            .PRN  (1'b1),
            .en   (en),
            .d    (d[i]),
            .q    (q[i])
        );
    end

endmodule

// File: rtl/rr_shared_reg_arb.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Handshake: a requester holds req[i] (with wdata slice valid) until it sees
// gnt[i]; each gnt[i] cycle reports exactly one write of that requester's data
// at the preceding edge. lock[i] only matters while i owns the register.
module rr_shared_reg_arb
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     CLRN,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         reg_q,
    output logic                     busy,
    output logic                     dbg_state
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t       state, nxt_state;
    logic [IDX_W-1:0] owner, nxt_owner;
    logic [IDX_W-1:0] ptr, nxt_ptr;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [IDX_W-1:0] win;
    logic             hold;
    logic             en;
    logic [WIDTH-1:0] sel_data;

    // First requester at or after p, wrapping; the previous owner sits at p-1
    // and is therefore naturally the lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Next-state decision: continue a locked burst, re-arbitrate, or go idle.
    always_comb begin
        nxt_state = IDLE;
        nxt_owner = owner;
        nxt_ptr   = ptr;
        nxt_cnt   = cnt;
        en        = 1'b0;
        win       = rr_pick(req, ptr);
        hold      = (state == OWN) && req[owner] && lock[owner] && (cnt < CNT_LAST);
        if (hold) begin
            nxt_state = OWN;
            nxt_cnt   = cnt + 1'b1;
            en        = 1'b1;
        end else if (|req) begin
            nxt_state = OWN;
            nxt_owner = win;
            nxt_cnt   = '0;
            nxt_ptr   = (win == IDX_LAST) ? '0 : win + 1'b1;
            en        = 1'b1;
        end
    end

    // Data of whichever requester writes at the coming edge.
    always_comb begin
        sel_data = wdata[int'(nxt_owner)*WIDTH +: WIDTH];
    end

    // Arbitration state, plus the registered one-hot grant for the write just made.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= nxt_state;
            owner <= nxt_owner;
            ptr   <= nxt_ptr;
            cnt   <= nxt_cnt;
            gnt   <= (nxt_state == OWN) ? (NUM_REQ'(1) << nxt_owner) : '0;
        end
    end

    en_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk  (clk),
        .CLRN (CLRN),
        .en   (en),
        .d    (sel_data),
        .q    (reg_q)
    );

    assign busy      = (state == OWN);
    assign dbg_state = state;

endmodule
